// File: rtl/display_pkg.sv
// display_pkg
//   Shared constants and the hex font for the multiplexed 7-segment scanner.
//   SEG_OFF    : segment pattern with every LED dark (active-low).
//   seg7_font  : nibble -> {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic logic [6:0] seg7_font(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_scan_ndigit_if.sv
// display_scan_ndigit_if
//   Bundles the digit/mask/control inputs and the pin outputs of the scanner.
//   master : register tap side (drives digit, dp, masks, lz_en, load, brightness;
//            observes node, segment, frame_tick)
//   slave  : scanner side
interface display_scan_ndigit_if #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BRIGHT_W = 4
);
  logic [4*N_DIGITS-1:0] digit;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [N_DIGITS-1:0]   blink_mask;
  logic                  lz_en;
  logic                  load;
  logic [BRIGHT_W-1:0]   brightness;
  logic [N_DIGITS-1:0]   node;
  logic [7:0]            segment;
  logic                  frame_tick;

  modport master (
    output digit, dp, blank_mask, blink_mask, lz_en, load, brightness,
    input  node, segment, frame_tick
  );

  modport slave (
    input  digit, dp, blank_mask, blink_mask, lz_en, load, brightness,
    output node, segment, frame_tick
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
//   Combinational hex nibble to 7-segment decoder.
//   i_nibble : hex value 0..F
//   o_seg    : {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  import display_pkg::*;

  always_comb begin
    o_seg = seg7_font(i_nibble);
  end
endmodule

// File: rtl/display_scan_ndigit.sv
// display_scan_ndigit
//   Multiplexed N-digit 7-segment driver with double-buffered digit data,
//   per-digit decimal points, blank/blink masks, leading-zero suppression
//   and PWM brightness.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : slave side of display_scan_ndigit_if
//          in : digit (nibble 0 = rightmost), dp, blank_mask, blink_mask,
//               lz_en, load (shadow capture strobe), brightness
//          out: node (active-low anodes), segment ({dp,g..a} active-low),
//               frame_tick (one cycle after the digit index wraps to 0)
module display_scan_ndigit #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned PRESCALE_W = 14,
  parameter int unsigned BRIGHT_W   = 4,
  parameter int unsigned BLINK_W    = 6
) (
  input logic                  clk,
  input logic                  rst,
  display_scan_ndigit_if.slave bus
);
  import display_pkg::*;

  localparam int unsigned      IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // scan timing
  logic [PRESCALE_W-1:0] r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [BLINK_W:0]      r_blink_cnt;
  logic                  w_presc_wrap;
  logic                  w_frame_end;
  logic                  w_blink_phase;

  // shadow (written by load) and active (displayed) buffers
  logic [4*N_DIGITS-1:0] r_sh_digit,  r_act_digit;
  logic [N_DIGITS-1:0]   r_sh_dp,     r_act_dp;
  logic [N_DIGITS-1:0]   r_sh_blank,  r_act_blank;
  logic [N_DIGITS-1:0]   r_sh_blink,  r_act_blink;
  logic                  r_sh_lz,     r_act_lz;

  // current-slot selection
  logic [N_DIGITS-1:0]   w_tail_zero;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_dark_sel;
  logic [N_DIGITS-1:0]   w_node_lit;
  logic                  w_pwm_on;
  logic [6:0]            w_seg7;

  // pins
  logic [N_DIGITS-1:0]   r_node;
  logic [7:0]            r_segment;
  logic                  r_frame_tick;

  assign w_presc_wrap  = &r_presc;
  assign w_frame_end   = w_presc_wrap && (r_idx == LAST_IDX);
  assign w_blink_phase = r_blink_cnt[BLINK_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_presc <= r_presc + PRESCALE_W'(1);
      if (w_presc_wrap) begin
        if (r_idx == LAST_IDX) begin
          r_idx       <= '0;
          r_blink_cnt <= r_blink_cnt + (BLINK_W + 1)'(1);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  // A load on the boundary edge bypasses the shadow so the new value is
  // shown in the frame that starts on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_digit  <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_sh_blink  <= '0;
      r_sh_lz     <= 1'b0;
      r_act_digit <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_act_blink <= '0;
      r_act_lz    <= 1'b0;
    end else begin
      if (bus.load) begin
        r_sh_digit <= bus.digit;
        r_sh_dp    <= bus.dp;
        r_sh_blank <= bus.blank_mask;
        r_sh_blink <= bus.blink_mask;
        r_sh_lz    <= bus.lz_en;
      end
      if (w_frame_end) begin
        if (bus.load) begin
          r_act_digit <= bus.digit;
          r_act_dp    <= bus.dp;
          r_act_blank <= bus.blank_mask;
          r_act_blink <= bus.blink_mask;
          r_act_lz    <= bus.lz_en;
        end else begin
          r_act_digit <= r_sh_digit;
          r_act_dp    <= r_sh_dp;
          r_act_blank <= r_sh_blank;
          r_act_blink <= r_sh_blink;
          r_act_lz    <= r_sh_lz;
        end
      end
    end
  end

  // w_tail_zero[i]: nibbles i..N_DIGITS-1 are all zero (walked from the left).
  always_comb begin : tail_zero_scan
    logic v_run;
    v_run       = 1'b1;
    w_tail_zero = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      v_run = v_run && (r_act_digit[4*(N_DIGITS-1-k) +: 4] == 4'h0);
      w_tail_zero[N_DIGITS-1-k] = v_run;
    end
  end

  always_comb begin
    w_nib      = '0;
    w_dp_sel   = 1'b0;
    w_dark_sel = 1'b0;
    w_node_lit = '1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib         = r_act_digit[4*k +: 4];
        w_dp_sel      = r_act_dp[k];
        w_dark_sel    = r_act_blank[k]
                      || (r_act_blink[k] && w_blink_phase)
                      || (r_act_lz && (k != 0) && w_tail_zero[k]);
        w_node_lit[k] = 1'b0;
      end
    end
  end

  assign w_pwm_on = (bus.brightness == '1)
                 || (r_presc[PRESCALE_W-1 -: BRIGHT_W] < bus.brightness);

  seg7_hex_decode u_decode (
    .i_nibble (w_nib),
    .o_seg    (w_seg7)
  );

  // Anode and pattern share one register stage so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_node       <= '1;
      r_segment    <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_dark_sel || !w_pwm_on) begin
        r_node    <= '1;
        r_segment <= SEG_OFF;
      end else begin
        r_node    <= w_node_lit;
        r_segment <= {~w_dp_sel, w_seg7};
      end
    end
  end

  assign bus.node       = r_node;
  assign bus.segment    = r_segment;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ndigit.sv
module tb_display_scan_ndigit;

  logic clk;
  logic rst;

  display_scan_ndigit_if #(.N_DIGITS(4), .BRIGHT_W(2)) bus4 ();
  display_scan_ndigit_if #(.N_DIGITS(3), .BRIGHT_W(2)) bus3 ();

  display_scan_ndigit #(
    .N_DIGITS   (4),
    .PRESCALE_W (4),
    .BRIGHT_W   (2),
    .BLINK_W    (1)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  display_scan_ndigit #(
    .N_DIGITS   (3),
    .PRESCALE_W (4),
    .BRIGHT_W   (2),
    .BLINK_W    (1)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since last reset; presc = cyc%16, frame boundary edges at cyc%64==0
  int unsigned cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  log_node [0:127];
  logic [7:0]  log_seg  [0:127];
  logic        log_ft   [0:127];
  int unsigned log_cyc  [0:127];

  logic [7:0] e_node [0:3];
  logic [7:0] e_seg  [0:3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic record(input bit sel, input int j);
    log_node[j] = sel ? {5'd0, bus3.node} : {4'd0, bus4.node};
    log_seg[j]  = sel ? bus3.segment : bus4.segment;
    log_ft[j]   = sel ? bus3.frame_tick : bus4.frame_tick;
    log_cyc[j]  = cyc;
  endtask

  // Stops on the negedge where frame_tick is high; that sample is j=0.
  // Sample j then shows idx (j-1)/16, prescaler (j-1)%16 of the new frame.
  task automatic sync_frame(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? bus3.frame_tick : bus4.frame_tick;
    end
    chk("frame_tick_seen", {31'd0, seen}, 32'd1);
    record(sel, 0);
  endtask

  task automatic run(input bit sel, input int from, input int to);
    for (int j = from; j <= to; j++) begin
      @(negedge clk);
      record(sel, j);
    end
  endtask

  task automatic load4(input logic [15:0] d, input logic [3:0] dpv,
                       input logic [3:0] blank, input logic [3:0] blink, input logic lz);
    bus4.digit      = d;
    bus4.dp         = dpv;
    bus4.blank_mask = blank;
    bus4.blink_mask = blink;
    bus4.lz_en      = lz;
    bus4.load       = 1'b1;
    @(negedge clk);
    bus4.load       = 1'b0;
  endtask

  task automatic chk_slots(input string tag, input int off);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_node"}, {24'd0, log_node[k*16 + off]}, {24'd0, e_node[k]});
      chk({tag, "_seg"},  {24'd0, log_seg[k*16 + off]},  {24'd0, e_seg[k]});
    end
  endtask

  initial begin
    int lit;
    int unsigned ph;

    rst = 1'b1;
    bus4.digit = '0; bus4.dp = '0; bus4.blank_mask = '0; bus4.blink_mask = '0;
    bus4.lz_en = 1'b0; bus4.load = 1'b0; bus4.brightness = 2'd3;
    bus3.digit = '0; bus3.dp = '0; bus3.blank_mask = '0; bus3.blink_mask = '0;
    bus3.lz_en = 1'b0; bus3.load = 1'b0; bus3.brightness = 2'd3;

    // 1. reset state, then 1234 at full brightness
    repeat (3) @(negedge clk);
    chk("rst_node",  {28'd0, bus4.node}, 32'hF);
    chk("rst_seg",   {24'd0, bus4.segment}, 32'hFF);
    chk("rst_ft",    {31'd0, bus4.frame_tick}, 32'd0);
    chk("rst_node3", {29'd0, bus3.node}, 32'h7);
    rst = 1'b0;

    load4(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    sync_frame(0);
    run(0, 1, 64);
    e_node = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
    e_seg  = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    chk_slots("t1_first", 1);
    chk_slots("t1_mid", 8);
    chk_slots("t1_last", 16);
    chk("t1_ft_pulse", {31'd0, log_ft[1]}, 32'd0);
    chk("t1_ft_mid",   {31'd0, log_ft[32]}, 32'd0);
    chk("t1_ft_wrap",  {31'd0, log_ft[64]}, 32'd1);

    // 2. leading-zero suppression
    load4(16'h00A5, 4'h0, 4'h0, 4'h0, 1'b1);
    sync_frame(0);
    run(0, 1, 64);
    e_node = '{8'h0E, 8'h0D, 8'h0F, 8'h0F};
    e_seg  = '{8'h92, 8'h88, 8'hFF, 8'hFF};
    chk_slots("t2_a5", 8);

    load4(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
    sync_frame(0);
    run(0, 1, 64);
    e_node = '{8'h0E, 8'h0F, 8'h0F, 8'h0F};
    e_seg  = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    chk_slots("t2_zero", 8);

    // 3. three-digit instance, decimal point on digit 1
    bus3.digit = 12'hFFF;
    bus3.dp    = 3'b010;
    bus3.load  = 1'b1;
    @(negedge clk);
    bus3.load  = 1'b0;
    sync_frame(1);
    run(1, 1, 49);
    chk("t3_node0", {24'd0, log_node[8]},  32'h6);
    chk("t3_seg0",  {24'd0, log_seg[8]},   32'h8E);
    chk("t3_node1", {24'd0, log_node[24]}, 32'h5);
    chk("t3_seg1",  {24'd0, log_seg[24]},  32'h0E);
    chk("t3_node2", {24'd0, log_node[40]}, 32'h3);
    chk("t3_seg2",  {24'd0, log_seg[40]},  32'h8E);
    chk("t3_ft_mid",  {31'd0, log_ft[24]}, 32'd0);
    chk("t3_ft_48",   {31'd0, log_ft[48]}, 32'd1);
    chk("t3_wrap_node", {24'd0, log_node[49]}, 32'h6);

    // 4. PWM brightness
    bus4.brightness = 2'd1;
    load4(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    sync_frame(0);
    run(0, 1, 64);
    chk("t4_p0_node", {24'd0, log_node[1]},  32'hE);
    chk("t4_p0_seg",  {24'd0, log_seg[1]},   32'h99);
    chk("t4_p3_node", {24'd0, log_node[4]},  32'hE);
    chk("t4_p4_node", {24'd0, log_node[5]},  32'hF);
    chk("t4_p4_seg",  {24'd0, log_seg[5]},   32'hFF);
    chk("t4_s1p0_node", {24'd0, log_node[17]}, 32'hD);
    chk("t4_s1p7_node", {24'd0, log_node[24]}, 32'hF);
    lit = 0;
    for (int j = 1; j <= 64; j++) if (log_node[j] != 8'h0F) lit++;
    chk("t4_lit_cnt", lit, 32'd16);

    bus4.brightness = 2'd0;
    sync_frame(0);
    run(0, 1, 64);
    lit = 0;
    for (int j = 1; j <= 64; j++) if (log_node[j] != 8'h0F) lit++;
    chk("t4_off_cnt", lit, 32'd0);

    // 5. double buffering: mid-frame load waits, boundary load is immediate
    bus4.brightness = 2'd3;
    sync_frame(0);
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      record(0, j);
      if (j == 20) begin
        bus4.digit = 16'h1111;
        bus4.load  = 1'b1;
      end
      if (j == 21) bus4.load = 1'b0;
    end
    chk("t5_old_s1", {24'd0, log_seg[30]},  32'hB0);
    chk("t5_old_s2", {24'd0, log_seg[40]},  32'hA4);
    chk("t5_old_n2", {24'd0, log_node[40]}, 32'hB);
    chk("t5_new_s0", {24'd0, log_seg[72]},  32'hF9);
    chk("t5_new_n0", {24'd0, log_node[72]}, 32'hE);

    sync_frame(0);
    for (int j = 1; j <= 88; j++) begin
      @(negedge clk);
      record(0, j);
      if (j == 63) begin
        bus4.digit = 16'h5678;
        bus4.load  = 1'b1;
      end
      if (j == 64) bus4.load = 1'b0;
    end
    chk("t5_bnd_ft",   {31'd0, log_ft[64]}, 32'd1);
    chk("t5_bnd_old3", {24'd0, log_seg[56]}, 32'hF9);
    chk("t5_bnd_s0",   {24'd0, log_seg[72]}, 32'h80);
    chk("t5_bnd_n0",   {24'd0, log_node[72]}, 32'hE);
    chk("t5_bnd_s1",   {24'd0, log_seg[88]}, 32'hF8);

    // blink on digit 0; phase = bit 1 of frames completed before the shown slot
    load4(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0);
    sync_frame(0);
    for (int f = 0; f < 4; f++) begin
      sync_frame(0);
      run(0, 1, 24);
      ph = ((log_cyc[8] - 1) / 64 / 2) % 2;
      chk("t5_blink_n0", {24'd0, log_node[8]}, (ph != 0) ? 32'hF  : 32'hE);
      chk("t5_blink_s0", {24'd0, log_seg[8]},  (ph != 0) ? 32'hFF : 32'h99);
      chk("t5_blink_n1", {24'd0, log_node[24]}, 32'hD);
    end

    // 6. reset pulse while idx2 is displayed
    sync_frame(0);
    run(0, 1, 40);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_node", {28'd0, bus4.node}, 32'hF);
    chk("t6_rst_seg",  {24'd0, bus4.segment}, 32'hFF);
    chk("t6_rst_ft",   {31'd0, bus4.frame_tick}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_resume_node", {28'd0, bus4.node}, 32'hE);
    chk("t6_resume_seg",  {24'd0, bus4.segment}, 32'hC0);
    sync_frame(0);
    run(0, 1, 24);
    chk("t6_sh_n0", {24'd0, log_node[8]},  32'hE);
    chk("t6_sh_s0", {24'd0, log_seg[8]},   32'hC0);
    chk("t6_sh_n1", {24'd0, log_node[24]}, 32'hD);
    chk("t6_sh_s1", {24'd0, log_seg[24]},  32'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
